// File: rtl/tick_rate_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tick_rate_scheduler
// Description : Shared prescaler producing base_tick, plus NUM_CH runtime-
//               programmable divisors producing single-cycle tick enables.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_rate_scheduler #(
  parameter int PRESCALE = 12000,
  parameter int NUM_CH   = 4,
  parameter int DIV_W    = 16,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic              run,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic              base_tick,
  output logic [NUM_CH-1:0] tick
);

  localparam int                 c_pre_w   = $clog2(PRESCALE);
  localparam logic [c_pre_w-1:0] c_pre_max = c_pre_w'(PRESCALE - 1);
  localparam logic [CH_W:0]      c_num_ch  = (CH_W + 1)'(NUM_CH);

  logic [c_pre_w-1:0] pre_cnt_q, pre_cnt_d;
  logic               base_tick_q, base_tick_d;
  logic [NUM_CH-1:0]  tick_q, tick_d;
  logic               cfg_err_q, cfg_err_d;
  logic [DIV_W-1:0]   div_q [NUM_CH];
  logic [DIV_W-1:0]   div_d [NUM_CH];
  logic [DIV_W-1:0]   cnt_q [NUM_CH];
  logic [DIV_W-1:0]   cnt_d [NUM_CH];

  logic w_cfg_accept;
  logic w_cfg_in_range;

  // Writes are refused while channels update, so config and tick logic never collide.
  assign cfg_ready      = ~base_tick_q & ~sync;
  assign w_cfg_accept   = cfg_valid & cfg_ready;
  assign w_cfg_in_range = ({1'b0, cfg_ch} < c_num_ch);

  assign base_tick = base_tick_q;
  assign tick      = tick_q;
  assign cfg_err   = cfg_err_q;

  always_comb begin
    pre_cnt_d   = pre_cnt_q;
    base_tick_d = 1'b0;
    if (sync) begin
      pre_cnt_d = '0;
    end else if (run) begin
      if (pre_cnt_q == c_pre_max) begin
        pre_cnt_d   = '0;
        base_tick_d = 1'b1;
      end else begin
        pre_cnt_d = pre_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    tick_d    = '0;
    cfg_err_d = w_cfg_accept & ~w_cfg_in_range;
    for (int i = 0; i < NUM_CH; i++) begin
      div_d[i] = div_q[i];
      cnt_d[i] = cnt_q[i];
      if (sync) begin
        cnt_d[i] = '0;
      end else if (base_tick_q) begin
        // A zero divisor parks the channel with its count held at 0.
        if (div_q[i] != '0) begin
          if (cnt_q[i] == div_q[i] - 1'b1) begin
            cnt_d[i]  = '0;
            tick_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
      end else if (w_cfg_accept && w_cfg_in_range && (cfg_ch == CH_W'(i))) begin
        div_d[i] = cfg_div;
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_q   <= '0;
      base_tick_q <= 1'b0;
      tick_q      <= '0;
      cfg_err_q   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      pre_cnt_q   <= pre_cnt_d;
      base_tick_q <= base_tick_d;
      tick_q      <= tick_d;
      cfg_err_q   <= cfg_err_d;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tick_rate_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_tick_rate_scheduler
// Description : Randomised bench for tick_rate_scheduler; two instances
//               (NUM_CH=4 and NUM_CH=5) against a modulo-arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_rate_scheduler;

  localparam int P     = 4;
  localparam int DIV_W = 8;

  logic clk_in  = 1'b0;
  logic reset_n = 1'b0;
  logic run     = 1'b0;
  logic sync    = 1'b0;

  logic             s_valid [2];
  logic [2:0]       s_ch    [2];
  logic [DIV_W-1:0] s_div   [2];

  logic       ready0, err0, base0;
  logic [3:0] tick0;
  logic       ready1, err1, base1;
  logic [4:0] tick1;
  logic [1:0] cfg_ch0;

  assign cfg_ch0 = s_ch[0][1:0];

  always #5 clk_in = ~clk_in;

  tick_rate_scheduler #(.PRESCALE(P), .NUM_CH(4), .DIV_W(DIV_W)) u_dut4 (
    .clk_in(clk_in), .reset_n(reset_n), .run(run), .sync(sync),
    .cfg_valid(s_valid[0]), .cfg_ready(ready0), .cfg_ch(cfg_ch0),
    .cfg_div(s_div[0]), .cfg_err(err0), .base_tick(base0), .tick(tick0)
  );

  tick_rate_scheduler #(.PRESCALE(P), .NUM_CH(5), .DIV_W(DIV_W)) u_dut5 (
    .clk_in(clk_in), .reset_n(reset_n), .run(run), .sync(sync),
    .cfg_valid(s_valid[1]), .cfg_ready(ready1), .cfg_ch(s_ch[1]),
    .cfg_div(s_div[1]), .cfg_err(err1), .base_tick(base1), .tick(tick1)
  );

  // Model: advancing-edge count and base ticks seen per channel, judged by modulo.
  int       n_ch [2] = '{4, 5};
  int       adv  [2];
  int       nb   [2][8];
  int       mdiv [2][8];
  bit       m_base [2];
  bit [7:0] m_tick [2];
  bit       m_err  [2];
  bit       acc    [2];
  bit       held   [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      adv[i]    = 0;
      m_base[i] = 1'b0;
      m_tick[i] = '0;
      m_err[i]  = 1'b0;
      held[i]   = 1'b0;
      for (int c = 0; c < 8; c++) begin
        nb[i][c]   = 0;
        mdiv[i][c] = 0;
      end
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit       nbase;
      bit [7:0] ntick;
      bit       nerr;
      bit       rdy;
      nbase = 1'b0;
      ntick = '0;
      nerr  = 1'b0;
      rdy   = !m_base[i] && !sync;
      acc[i]  = s_valid[i] && rdy;
      held[i] = s_valid[i] && !rdy;
      if (sync) begin
        adv[i] = 0;
        for (int c = 0; c < 8; c++) nb[i][c] = 0;
      end else begin
        if (run) begin
          adv[i]++;
          if (adv[i] % P == 0) nbase = 1'b1;
        end
        if (m_base[i]) begin
          for (int c = 0; c < n_ch[i]; c++) begin
            if (mdiv[i][c] != 0) begin
              nb[i][c]++;
              if (nb[i][c] % mdiv[i][c] == 0) ntick[c] = 1'b1;
            end
          end
        end else if (acc[i]) begin
          if (int'(s_ch[i]) < n_ch[i]) begin
            mdiv[i][s_ch[i]] = int'(s_div[i]);
            nb[i][s_ch[i]]   = 0;
          end else begin
            nerr = 1'b1;
          end
        end
      end
      m_base[i] = nbase;
      m_tick[i] = ntick;
      m_err[i]  = nerr;
    end
  endtask

  task automatic check_ready();
    check("cfg_ready0", ready0, !m_base[0] && !sync);
    check("cfg_ready1", ready1, !m_base[1] && !sync);
  endtask

  task automatic check_outs();
    check("base_tick0", base0, m_base[0]);
    check("tick0",      tick0, m_tick[0][3:0]);
    check("cfg_err0",   err0,  m_err[0]);
    check("base_tick1", base1, m_base[1]);
    check("tick1",      tick1, m_tick[1][4:0]);
    check("cfg_err1",   err1,  m_err[1]);
  endtask

  // Inputs are set at a falling edge before calling; one full clock follows.
  task automatic step();
    #1;
    check_ready();
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
    check_outs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_outs();
    check_ready();
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_outs();
    reset_n = 1'b1;
  endtask

  task automatic write(input int i, input int ch, input int dv);
    bit done;
    done = 1'b0;
    s_valid[i] = 1'b1;
    s_ch[i]    = 3'(ch);
    s_div[i]   = DIV_W'(dv);
    for (int k = 0; k < 20 && !done; k++) begin
      step();
      done = acc[i];
    end
    if (!done) check("write_accept_timeout", 32'd0, 32'd1);
    s_valid[i] = 1'b0;
  endtask

  task automatic rand_inputs(input int run_pct, input int sync_pct, input int valid_pct);
    run  = ($urandom % 100) < run_pct;
    sync = ($urandom % 100) < sync_pct;
    for (int i = 0; i < 2; i++) begin
      if (!held[i]) begin
        s_valid[i] = ($urandom % 100) < valid_pct;
        s_ch[i]    = (i == 0) ? 3'($urandom % 4) : 3'($urandom % 8);
        s_div[i]   = (($urandom % 8) == 0) ? DIV_W'($urandom % 256) : DIV_W'($urandom % 6);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      s_valid[i] = 1'b0;
      s_ch[i]    = '0;
      s_div[i]   = '0;
    end
    model_reset();
    do_reset();

    // Free-running base_tick with no channels programmed.
    run = 1'b1;
    idle(20);

    // Channel 0 every base tick, channel 1 every third.
    write(0, 0, 1);
    write(0, 1, 3);
    write(1, 0, 1);
    write(1, 1, 3);
    idle(30);

    // Disable a channel that is ticking at 2.
    write(0, 2, 2);
    idle(16);
    write(0, 2, 0);
    idle(16);

    // Write held across a base_tick cycle.
    idle(2);
    write(0, 3, 2);
    idle(12);

    // Out-of-range channel on the NUM_CH=5 instance.
    write(1, 5, 2);
    idle(4);
    write(1, 7, 1);
    idle(4);

    // Freeze mid-period, resume, sync, then reset mid-run.
    idle(1);
    run = 1'b0;
    idle(10);
    run = 1'b1;
    idle(9);
    sync = 1'b1;
    step();
    sync = 1'b0;
    idle(20);
    do_reset();
    idle(12);

    // Randomised traffic with occasional mid-run resets.
    for (int n = 0; n < 2400; n++) begin
      if (n == 800 || n == 1600) begin
        run  = 1'b1;
        sync = 1'b0;
        do_reset();
      end
      rand_inputs(85, 3, 30);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
